// File: rtl/cpu_defs.sv
// Shared RV32I control definitions: opcodes, class codes, FSM encoding and datapath mux selects.
package cpu_defs;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpFence  = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    typedef enum logic [3:0] {
        ClsR,
        ClsImm,
        ClsLui,
        ClsAuipc,
        ClsJal,
        ClsJalr,
        ClsBranch,
        ClsLoad,
        ClsStore,
        ClsFence,
        ClsSystem
    } instr_class_e;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StFetch  = 3'd1;
    localparam logic [2:0] StDecode = 3'd2;
    localparam logic [2:0] StExec   = 3'd3;
    localparam logic [2:0] StMem    = 3'd4;
    localparam logic [2:0] StWb     = 3'd5;
    localparam logic [2:0] StHalt   = 3'd6;
    localparam logic [2:0] StTrap   = 3'd7;

    localparam logic       AluASelRs1   = 1'b0;
    localparam logic       AluASelPc    = 1'b1;
    localparam logic       AluBSelRs2   = 1'b0;
    localparam logic       AluBSelImm   = 1'b1;

    localparam logic [1:0] PcSelPlus4   = 2'd0;
    localparam logic [1:0] PcSelPlusImm = 2'd1;
    localparam logic [1:0] PcSelAlu     = 2'd2;

    localparam logic [1:0] WbSelAlu     = 2'd0;
    localparam logic [1:0] WbSelLoad    = 2'd1;
    localparam logic [1:0] WbSelPc4     = 2'd2;
    localparam logic [1:0] WbSelImm     = 2'd3;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Sequencer bundle: memory handshakes, datapath controls and status, seen from controller (master).
interface multicycle_ctrl_if;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        branch_taken;
    logic [31:0] ir;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic [1:0]  pc_sel;
    logic [1:0]  wb_sel;
    logic        pc_we;
    logic        rf_we;
    logic        retire;
    logic [31:0] instret;
    logic        halted;
    logic        illegal;
    logic        bus_err;

    modport master (
        output imem_req, dmem_req, dmem_we, ir, alu_a_sel, alu_b_sel, pc_sel, wb_sel,
               pc_we, rf_we, retire, instret, halted, illegal, bus_err,
        input  imem_ack, imem_rdata, dmem_ack, branch_taken
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we, ir, alu_a_sel, alu_b_sel, pc_sel, wb_sel,
               pc_we, rf_we, retire, instret, halted, illegal, bus_err,
        output imem_ack, imem_rdata, dmem_ack, branch_taken
    );
endinterface

// File: rtl/instr_class_dec.sv
// Combinational opcode classifier; shared with the pipelined core's hazard logic.
module instr_class_dec
    import cpu_defs::*;
(
    input  logic [6:0]   opcode_i,
    output instr_class_e cls_o,
    output logic         illegal_o
);

    always_comb begin
        cls_o     = ClsR;
        illegal_o = 1'b0;
        case (opcode_i)
            OpR:      cls_o = ClsR;
            OpImm:    cls_o = ClsImm;
            OpLui:    cls_o = ClsLui;
            OpAuipc:  cls_o = ClsAuipc;
            OpJal:    cls_o = ClsJal;
            OpJalr:   cls_o = ClsJalr;
            OpBranch: cls_o = ClsBranch;
            OpLoad:   cls_o = ClsLoad;
            OpStore:  cls_o = ClsStore;
            OpFence:  cls_o = ClsFence;
            OpSystem: cls_o = ClsSystem;
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: fetch, decode, execute, memory, writeback with bus timeout.
module multicycle_ctrl
    import cpu_defs::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);

    logic [2:0]   state_q, state_d;
    logic [31:0]  ir_q, ir_d;
    logic [31:0]  instret_q, instret_d;
    logic [31:0]  wait_q, wait_d;
    logic         taken_q, taken_d;
    logic         halted_q, halted_d;
    logic         illegal_q, illegal_d;
    logic         bus_err_q, bus_err_d;

    instr_class_e cls;
    logic         dec_illegal;
    logic         is_mem;
    logic         timeout_hit;

    instr_class_dec u_dec (
        .opcode_i  (ir_q[6:0]),
        .cls_o     (cls),
        .illegal_o (dec_illegal)
    );

    assign is_mem      = (cls == ClsLoad) || (cls == ClsStore);
    // The current wait cycle is the last one allowed without an ack.
    assign timeout_hit = (MEM_TIMEOUT != 0) && ((wait_q + 32'd1) == 32'(MEM_TIMEOUT));

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        instret_d = instret_q;
        wait_d    = '0;
        taken_d   = taken_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    state_d = StDecode;
                end else if (timeout_hit) begin
                    state_d   = StTrap;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            StDecode: begin
                if (dec_illegal) begin
                    state_d   = StTrap;
                    illegal_d = 1'b1;
                end else if (cls == ClsSystem) begin
                    state_d  = StHalt;
                    halted_d = 1'b1;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cls == ClsBranch) taken_d = bus.branch_taken;
                state_d = is_mem ? StMem : StWb;
            end
            StMem: begin
                if (bus.dmem_ack) begin
                    state_d = StWb;
                end else if (timeout_hit) begin
                    state_d   = StTrap;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            StWb: begin
                instret_d = instret_q + 32'd1;
                state_d   = StFetch;
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        bus.imem_req  = (state_q == StFetch);
        bus.dmem_req  = (state_q == StMem);
        bus.dmem_we   = (state_q == StMem) && (cls == ClsStore);
        bus.ir        = ir_q;
        bus.instret   = instret_q;
        bus.halted    = halted_q;
        bus.illegal   = illegal_q;
        bus.bus_err   = bus_err_q;
        bus.alu_a_sel = AluASelRs1;
        bus.alu_b_sel = AluBSelRs2;
        bus.pc_sel    = PcSelPlus4;
        bus.wb_sel    = WbSelAlu;
        bus.pc_we     = 1'b0;
        bus.rf_we     = 1'b0;
        bus.retire    = 1'b0;
        // Operand selects stay up through MEM/WB so the ALU result is stable at writeback.
        if ((state_q == StExec) || (state_q == StMem) || (state_q == StWb)) begin
            if ((cls == ClsAuipc) || (cls == ClsJal)) bus.alu_a_sel = AluASelPc;
            if ((cls == ClsImm) || (cls == ClsLoad) || (cls == ClsStore) ||
                (cls == ClsJalr) || (cls == ClsAuipc)) begin
                bus.alu_b_sel = AluBSelImm;
            end
        end
        if (state_q == StWb) begin
            bus.pc_we  = 1'b1;
            bus.retire = 1'b1;
            bus.rf_we  = (cls == ClsR) || (cls == ClsImm) || (cls == ClsLui) ||
                         (cls == ClsAuipc) || (cls == ClsJal) || (cls == ClsJalr) ||
                         (cls == ClsLoad);
            case (cls)
                ClsLui:            bus.wb_sel = WbSelImm;
                ClsJal, ClsJalr:   bus.wb_sel = WbSelPc4;
                ClsLoad:           bus.wb_sel = WbSelLoad;
                default:           bus.wb_sel = WbSelAlu;
            endcase
            case (cls)
                ClsJal:    bus.pc_sel = PcSelPlusImm;
                ClsBranch: bus.pc_sel = taken_q ? PcSelPlusImm : PcSelPlus4;
                ClsJalr:   bus.pc_sel = PcSelAlu;
                default:   bus.pc_sel = PcSelPlus4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            ir_q      <= '0;
            instret_q <= '0;
            wait_q    <= '0;
            taken_q   <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
            wait_q    <= wait_d;
            taken_q   <= taken_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control sequencer for the multi-cycle variant of the RV32I core. It fetches each instruction over a req/ack instruction-memory handshake and latches it into the instruction register. The IR feeds the immediate generator and register-file decode. The block then steps the shared datapath (ALU, data memory, register file, PC) through decode, execute, memory and writeback, emitting one-cycle write strobes, mux selects and a retire pulse per instruction.

## Interface
- MEM_TIMEOUT, 255: max wait cycles for a memory ack before bus-error trap; 0 disables the timeout
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
- dmem_ack  in  1  data access complete this cycle
- branch_taken  in  1  branch comparator result from the ALU
- ir  out  32  instruction register; feeds the immediate generator
- alu_a_sel  out  1  0 = rs1, 1 = PC
- alu_b_sel  out  1  0 = rs2, 1 = immediate
- pc_sel  out  2  0 = PC+4, 1 = PC+imm, 2 = ALU result with bit 0 cleared
- wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4, 3 = immediate
- pc_we, rf_we  out  1 each  single-cycle write strobes
- retire  out  1  one pulse per completed instruction
- instret  out  32  retired-instruction count
- halted, illegal, bus_err  out  1 each  sticky status

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP.
- Reset: state IDLE, ir=0, instret=0, wait counter 0, all outputs 0. IDLE always goes to FETCH on the next cycle.
- FETCH: imem_req=1. When imem_ack is high, ir<=imem_rdata and the next state is DECODE; otherwise stay in FETCH.
- DECODE: classify ir[6:0] as R, IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, FENCE or SYSTEM.
  - Any other opcode goes to TRAP with illegal=1.
  - SYSTEM goes to HALT with halted=1.
  - All other classes go to EXEC.
- EXEC: drive alu_a_sel/alu_b_sel for the class.
  - AUIPC and JAL: a=PC.
  - IMM, LOAD, STORE, JALR, AUIPC: b=imm.
  - BRANCH: latch branch_taken into taken_q.
  - LOAD and STORE go to MEM; all other classes go to WB.
- MEM: dmem_req=1, dmem_we=(STORE). On dmem_ack go to WB.
- WB: pc_we=1, retire=1, instret+=1 (wraps at 2^32).
  - rf_we=1 for R, IMM, LUI, AUIPC, JAL, JALR, LOAD.
  - wb_sel: LUI=3, JAL/JALR=2, LOAD=1, else 0.
  - pc_sel: JAL=1, BRANCH=taken_q?1:0, JALR=2, else 0.
  - Next state FETCH.
- FENCE retires as a no-op.
- HALT and TRAP are absorbing. No strobes or requests are issued; only reset exits them.
- Timeout: the wait counter increments each FETCH/MEM cycle without an ack and clears on ack or state change. When it reaches MEM_TIMEOUT with MEM_TIMEOUT≠0, go to TRAP with bus_err=1. The request drops the next cycle.

## Timing
- All outputs decode from registered state and ir only, with no combinational path from the ack inputs. The exception is retire/instret, which update at the WB edge.
- Once asserted, a request holds with stable dmem_we until ack, reset or timeout. It is never withdrawn otherwise.
- An ack with no request outstanding is ignored.
- Latency with zero-wait acks: FETCH→DECODE→EXEC→WB is 4 cycles per ALU/branch/jump instruction; load/store take 5. Each memory wait cycle adds 1.
- pc_we, rf_we and retire are high for exactly one cycle, in WB only. rf_we is never high in the same cycle as dmem_req.
- Reset asserted mid-operation: all outputs are 0 on the cycle after the sampling edge. The interrupted instruction does not retire.

## Structure
- Shared package cpu_defs holds:
  - the opcode constants
  - the state encoding
  - the pc_sel/wb_sel/alu-select encodings, also used by the datapath muxes
- Sub-module instr_class_dec: combinational ir[6:0] → class code plus illegal flag. It is reused by the hazard logic of the pipelined core.

## Test plan
- ADDI x1,x0,5 (0x00500093), imem_ack same cycle → 4 cycles FETCH..WB; rf_we, wb_sel=0, alu_b_sel=1 in WB; instret=1.
- LW 0x0000A103, dmem_ack 3 cycles late → dmem_req high 4 cycles with dmem_we=0; WB wb_sel=1, rf_we=1; 8 cycles total.
- BEQ with branch_taken=1 vs 0 → WB pc_sel=1 vs 0, rf_we=0 both; JALR → pc_sel=2, wb_sel=2.
- Opcode 0x0000007F → TRAP, illegal=1, no retire, imem_req stays 0 until reset; ECALL 0x00000073 → halted=1.
- MEM_TIMEOUT=4, imem_ack held low → TRAP with bus_err=1 after 4 FETCH cycles; imem_req low on the next cycle.
- Reset pulsed during MEM of a SW → dmem_req 0 on the next cycle, instret=0, restart at IDLE→FETCH.
